// File: rtl/regfile_sb.sv
// 31x32 register file with a per-register 2-bit pending-writer scoreboard.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_rd_enable,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_data,
    input  logic        read1_enable,
    input  logic [4:0]  read1_addr,
    input  logic        read2_enable,
    input  logic [4:0]  read2_addr,
    output logic [31:0] read1_data,
    output logic [31:0] read2_data,
    output logic        read1_busy,
    output logic        read2_busy,
    input  logic        issue_enable,
    input  logic [4:0]  issue_addr,
    input  logic        squash_enable,
    input  logic [4:0]  squash_addr,
    output logic        sb_error
);

    localparam int RegAddrlen = 5;
    localparam int Reglen     = 32;
    localparam logic [Reglen-1:0] ZeroWord = '0;

    // Entry 0 of each array is only ever reset, so x0 stays zero with no pending writer.
    logic [Reglen-1:0] regs     [0:31];
    logic [1:0]        pend     [0:31];
    logic [1:0]        pend_nxt [0:31];
    logic              err_nxt;
    int                delta;
    int                sum;

    always_comb begin
        pend_nxt = pend;
        err_nxt  = 1'b0;
        delta    = 0;
        sum      = 0;
        for (int r = 1; r < 32; r++) begin
            delta = 0;
            if (issue_enable && issue_addr == RegAddrlen'(r))
                delta = delta + 1;
            if (wb_rd_enable && wb_rd_addr == RegAddrlen'(r))
                delta = delta - 1;
            if (squash_enable && squash_addr == RegAddrlen'(r))
                delta = delta - 1;
            sum = int'(pend[r]) + delta;
            if (sum > 3) begin
                pend_nxt[r] = 2'd3;
                err_nxt     = 1'b1;
            end else if (sum < 0) begin
                pend_nxt[r] = 2'd0;
                err_nxt     = 1'b1;
            end else begin
                pend_nxt[r] = 2'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= ZeroWord;
                pend[i] <= 2'd0;
            end
            sb_error <= 1'b0;
        end else begin
            if (wb_rd_enable && wb_rd_addr != '0)
                regs[wb_rd_addr] <= wb_rd_data;
            for (int i = 1; i < 32; i++)
                pend[i] <= pend_nxt[i];
            if (err_nxt)
                sb_error <= 1'b1;
        end
    end

    logic rd1_valid;
    logic rd2_valid;
    assign rd1_valid = read1_enable && read1_addr != '0;
    assign rd2_valid = read2_enable && read2_addr != '0;

`ifdef REGFILE_BYPASS_EN
    // A retiring sole writer hands its data straight to the reader, unless a new writer issues now.
    logic rd1_hit;
    logic rd2_hit;
    assign rd1_hit = !rst && wb_rd_enable && rd1_valid && wb_rd_addr == read1_addr;
    assign rd2_hit = !rst && wb_rd_enable && rd2_valid && wb_rd_addr == read2_addr;

    assign read1_data = !rd1_valid ? ZeroWord : (rd1_hit ? wb_rd_data : regs[read1_addr]);
    assign read2_data = !rd2_valid ? ZeroWord : (rd2_hit ? wb_rd_data : regs[read2_addr]);

    assign read1_busy = rd1_valid && pend[read1_addr] != 2'd0 &&
                        !(rd1_hit && pend[read1_addr] == 2'd1 &&
                          !(issue_enable && issue_addr == read1_addr));
    assign read2_busy = rd2_valid && pend[read2_addr] != 2'd0 &&
                        !(rd2_hit && pend[read2_addr] == 2'd1 &&
                          !(issue_enable && issue_addr == read2_addr));
`else
    assign read1_data = rd1_valid ? regs[read1_addr] : ZeroWord;
    assign read2_data = rd2_valid ? regs[read2_addr] : ZeroWord;
    assign read1_busy = rd1_valid && pend[read1_addr] != 2'd0;
    assign read2_busy = rd2_valid && pend[read2_addr] != 2'd0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_rd_enable;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        read1_enable, read2_enable;
    logic [4:0]  read1_addr, read2_addr;
    logic [31:0] read1_data, read2_data;
    logic        read1_busy, read2_busy;
    logic        issue_enable, squash_enable;
    logic [4:0]  issue_addr, squash_addr;
    logic        sb_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .wb_rd_enable(wb_rd_enable), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .read1_enable(read1_enable), .read1_addr(read1_addr),
        .read2_enable(read2_enable), .read2_addr(read2_addr),
        .read1_data(read1_data), .read2_data(read2_data),
        .read1_busy(read1_busy), .read2_busy(read2_busy),
        .issue_enable(issue_enable), .issue_addr(issue_addr),
        .squash_enable(squash_enable), .squash_addr(squash_addr),
        .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    // Reference: each register's count of un-retired writers, clamped to 0..3.
    task automatic model_step();
        int n;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
        end else begin
            if (wb_rd_enable && wb_rd_addr != 0)
                m_regs[wb_rd_addr] = wb_rd_data;
            for (int r = 1; r < 32; r++) begin
                n = m_cnt[r];
                if (issue_enable && issue_addr == r) n = n + 1;
                if (wb_rd_enable && wb_rd_addr == r) n = n - 1;
                if (squash_enable && squash_addr == r) n = n - 1;
                if (n > 3) begin n = 3; m_err = 1'b1; end
                if (n < 0) begin n = 0; m_err = 1'b1; end
                m_cnt[r] = n;
            end
        end
    endtask

    function automatic logic [31:0] exp_data(logic en, logic [4:0] a);
        if (!en || a == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && wb_rd_enable && wb_rd_addr == a) return wb_rd_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(logic en, logic [4:0] a);
        if (!en || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && wb_rd_enable && wb_rd_addr == a && m_cnt[a] == 1 &&
            !(issue_enable && issue_addr == a)) return 1'b0;
`endif
        return m_cnt[a] != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_idle();
        rst = 1'b0;
        wb_rd_enable = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
        read1_enable = 1'b0; read1_addr = '0;
        read2_enable = 1'b0; read2_addr = '0;
        issue_enable = 1'b0; issue_addr = '0;
        squash_enable = 1'b0; squash_addr = '0;
    endtask

    task automatic do_reset();
        apply_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        read1_enable = 1'b1; read1_addr = 5'd5;
        #2;
        checks++;
        if (read1_data !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_data got %h want 0", read1_data);
        end
        checks++;
        if (read1_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy got %b want 0", read1_busy);
        end
        checks++;
        if (sb_error !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sb_error got %b want 0", sb_error);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        do_reset();
        wb_rd_enable = 1'b1; wb_rd_addr = 5'd7; wb_rd_data = 32'hDEADBEEF;
        read1_enable = 1'b1; read1_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
        want = 32'hDEADBEEF;
`else
        want = 32'd0;
`endif
        #2;
        checks++;
        if (read1_data !== want) begin
            errors++; $display("[TB] FAIL bypass_same_cycle got %h want %h", read1_data, want);
        end
        tick();
        wb_rd_enable = 1'b0;
        #2;
        checks++;
        if (read1_data !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL bypass_next_cycle got %h want deadbeef", read1_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        read1_enable = 1'b1; read1_addr = 5'd3;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            issue_enable = (cyc <= 3);
            issue_addr   = 5'd3;
            wb_rd_enable = (cyc >= 4 && cyc <= 6);
            wb_rd_addr   = 5'd3;
            wb_rd_data   = 32'h100 + cyc;
            #2;
            checks++;
            if (read1_busy !== exp_busy(1'b1, 5'd3)) begin
                errors++;
                $display("[TB] FAIL b2b_busy cycle %0d got %b want %b", cyc, read1_busy, exp_busy(1'b1, 5'd3));
            end
            tick();
        end
        apply_idle();
        read1_enable = 1'b1; read1_addr = 5'd3;
        #2;
        checks++;
        if (read1_busy !== 1'b0 || sb_error !== 1'b0 || read1_data !== 32'h106) begin
            errors++;
            $display("[TB] FAIL b2b_final busy %b err %b data %h want 0 0 00000106", read1_busy, sb_error, read1_data);
        end
    endtask

    task automatic test_same_cycle_issue_wb();
        do_reset();
        issue_enable = 1'b1; issue_addr = 5'd9;
        tick();
        wb_rd_enable = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'hCAFE0009;
        read1_enable = 1'b1; read1_addr = 5'd9;
        #2;
        checks++;
        if (read1_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL issue_wb_busy_now got %b want 1", read1_busy);
        end
        tick();
        apply_idle();
        read1_enable = 1'b1; read1_addr = 5'd9;
        #2;
        checks++;
        if (read1_busy !== 1'b1 || read1_data !== 32'hCAFE0009 || sb_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL issue_wb_after busy %b data %h err %b want 1 cafe0009 0", read1_busy, read1_data, sb_error);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        issue_enable = 1'b1; issue_addr = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            checks++;
            if (sb_error !== (k == 4)) begin
                errors++; $display("[TB] FAIL saturate_err after issue %0d got %b", k, sb_error);
            end
        end
        apply_idle();
        wb_rd_enable = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h1234;
        tick();
        apply_idle();
        read1_enable = 1'b1; read1_addr = 5'd0;
        read2_enable = 1'b1; read2_addr = 5'd4;
        #2;
        checks++;
        if (read1_data !== 32'd0 || read1_busy !== 1'b0 || read2_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL x0_write data %h busy0 %b busy4 %b want 0 0 1", read1_data, read1_busy, read2_busy);
        end
        // Three WBs must drain a saturated counter to idle.
        wb_rd_enable = 1'b1; wb_rd_addr = 5'd4; wb_rd_data = 32'h44;
        tick(); tick(); tick();
        wb_rd_enable = 1'b0;
        #2;
        checks++;
        if (read2_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL saturate_drain got %b want 0", read2_busy);
        end
    endtask

    task automatic test_squash();
        do_reset();
        issue_enable = 1'b1; issue_addr = 5'd12;
        tick();
        apply_idle();
        squash_enable = 1'b1; squash_addr = 5'd12;
        tick();
        apply_idle();
        read1_enable = 1'b1; read1_addr = 5'd12;
        #2;
        checks++;
        if (read1_busy !== 1'b0 || sb_error !== 1'b0) begin
            errors++; $display("[TB] FAIL squash_busy got %b err %b want 0 0", read1_busy, sb_error);
        end
        wb_rd_enable = 1'b1; wb_rd_addr = 5'd12; wb_rd_data = 32'h0000_0C0C;
        tick();
        wb_rd_enable = 1'b0;
        #2;
        checks++;
        if (sb_error !== 1'b1 || read1_data !== 32'h0000_0C0C) begin
            errors++; $display("[TB] FAIL squash_late_wb err %b data %h want 1 00000c0c", sb_error, read1_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] ed1, ed2;
        logic        eb1, eb2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst           = ($urandom_range(0, 79) == 0);
            issue_enable  = $urandom_range(0, 1);
            issue_addr    = 5'($urandom_range(0, 7));
            wb_rd_enable  = $urandom_range(0, 1);
            wb_rd_addr    = 5'($urandom_range(0, 7));
            wb_rd_data    = $urandom;
            squash_enable = ($urandom_range(0, 5) == 0);
            squash_addr   = 5'($urandom_range(0, 7));
            read1_enable  = ($urandom_range(0, 7) != 0);
            read1_addr    = 5'($urandom_range(0, 7));
            read2_enable  = ($urandom_range(0, 7) != 0);
            read2_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            // Errors are sticky, so clear them regularly to keep checking the flag's set path.
            if (cyc % 150 == 0) rst = 1'b1;
            #2;
            ed1 = exp_data(read1_enable, read1_addr);
            ed2 = exp_data(read2_enable, read2_addr);
            eb1 = exp_busy(read1_enable, read1_addr);
            eb2 = exp_busy(read2_enable, read2_addr);
            checks++;
            if (read1_data !== ed1 || read1_busy !== eb1) begin
                errors++;
                $display("[TB] FAIL rand_port1 cyc %0d addr %0d data %h busy %b want %h %b",
                         cyc, read1_addr, read1_data, read1_busy, ed1, eb1);
            end
            checks++;
            if (read2_data !== ed2 || read2_busy !== eb2) begin
                errors++;
                $display("[TB] FAIL rand_port2 cyc %0d addr %0d data %h busy %b want %h %b",
                         cyc, read2_addr, read2_data, read2_busy, ed2, eb2);
            end
            checks++;
            if (sb_error !== m_err) begin
                errors++; $display("[TB] FAIL rand_sb_error cyc %0d got %b want %b", cyc, sb_error, m_err);
            end
            tick();
        end
        apply_idle();
    endtask

    initial begin
        apply_idle();
        test_reset();
        test_bypass();
        test_back_to_back();
        test_same_cycle_issue_wb();
        test_saturate();
        test_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
